// File: rtl/result_writeback_serializer.sv
// Result writeback serializer: buffers wide PE-array result words in a small
// FIFO and drains each word to the result SRAM as NBEAT narrow beats over a
// valid/ready write port. Beat address is {word address, beat index}.
module result_writeback_serializer #(
  parameter int RES_W  = 8192,
  parameter int BEAT_W = 1024,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   res_en,
  input  logic [ADDR_W-1:0]                      res_addr,
  input  logic [RES_W-1:0]                       res_data,
  output logic                                   res_ready,
  output logic                                   wr_valid,
  input  logic                                   wr_ready,
  output logic [ADDR_W+$clog2(RES_W/BEAT_W)-1:0] wr_addr,
  output logic [BEAT_W-1:0]                      wr_data,
  output logic                                   busy,
  output logic                                   overflow,
  output logic [15:0]                            words_done
);

  localparam int NBEAT  = RES_W / BEAT_W;
  localparam int BIDX_W = $clog2(NBEAT);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NBEAT - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         remain;
  logic [BIDX_W-1:0]        beat_q, beat_d;
  logic                     wr_valid_q, wr_valid_d;
  logic [ADDR_W+BIDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [BEAT_W-1:0]        wr_data_q, wr_data_d;
  logic                     overflow_q, overflow_d;
  logic [15:0]              words_done_q, words_done_d;

  // FIFO storage, read only through the registered beat outputs
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [RES_W-1:0]  data_mem [DEPTH];

  logic              full, beat_fire, last_beat, pop, push, drop, bypass;
  logic [ADDR_W-1:0] head_addr_nx;
  logic [RES_W-1:0]  head_data_nx;
  logic [BEAT_W-1:0] head_beats [NBEAT];

  // Handshake decode, occupancy and pointer/beat next-state
  always_comb begin
    full      = (count_q == FULL_CNT);
    beat_fire = wr_valid_q & wr_ready;
    last_beat = (beat_q == LAST_BEAT);
    pop       = beat_fire & last_beat;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    push      = res_en & (~full | pop);
    drop      = res_en & full & ~pop;
    remain    = count_q - CNT_W'(pop);
    count_d   = remain + CNT_W'(push);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    beat_d    = beat_q;
    if (pop) begin
      beat_d = '0;
    end else if (beat_fire) begin
      beat_d = beat_q + 1'b1;
    end
    // When nothing else remains, the incoming word is next cycle's head and
    // is not yet in storage, so forward it straight from the input.
    bypass       = push & (remain == '0);
    head_addr_nx = bypass ? res_addr : addr_mem[rd_ptr_d];
    head_data_nx = bypass ? res_data : data_mem[rd_ptr_d];
  end

  // Slice the next head word into its beats
  for (genvar gi = 0; gi < NBEAT; gi++) begin : g_beat_slice
    assign head_beats[gi] = head_data_nx[gi*BEAT_W +: BEAT_W];
  end

  // Next values of the registered write port and the status counters
  always_comb begin
    wr_valid_d = (count_d != '0);
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (wr_valid_d) begin
      wr_addr_d = {head_addr_nx, beat_d};
      wr_data_d = head_beats[beat_d];
    end
    overflow_d   = overflow_q | drop;
    words_done_d = words_done_q + 16'(pop);
  end

  // FSM next state: STREAM while any word is buffered
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = STREAM;
      STREAM:  if (pop && (remain == '0) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= res_addr;
      data_mem[wr_ptr_q] <= res_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
      words_done_q <= words_done_d;
    end
  end

  assign res_ready  = ~full;
  assign busy       = (state_q == STREAM) | push;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign overflow   = overflow_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_result_writeback_serializer.sv
// Self-checking bench for result_writeback_serializer: a transaction-level
// reference model (queue of buffered words + beat index of the head) predicts
// the beat stream; each scenario task compares the observed stream and flags.
module tb_result_writeback_serializer;

  localparam int RES_W  = 8192;
  localparam int BEAT_W = 1024;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 2;
  localparam int NBEAT  = 8;
  localparam int WA_W   = ADDR_W + 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              res_en = 1'b0;
  logic [ADDR_W-1:0] res_addr = '0;
  logic [RES_W-1:0]  res_data = '0;
  logic              res_ready;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [WA_W-1:0]   wr_addr;
  logic [BEAT_W-1:0] wr_data;
  logic              busy;
  logic              overflow;
  logic [15:0]       words_done;

  always #5 clk = ~clk;

  result_writeback_serializer #(
    .RES_W(RES_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .res_en(res_en), .res_addr(res_addr), .res_data(res_data), .res_ready(res_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .overflow(overflow), .words_done(words_done)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [RES_W-1:0]  data;
  } word_t;

  typedef struct {
    logic [WA_W-1:0]   addr;
    logic [BEAT_W-1:0] data;
    int                cyc;
  } beat_t;

  // Reference model state
  word_t       m_q[$];
  int          m_beat = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_done = '0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    cyc_no = 0;
  int    tests_run = 0;
  int    tests_failed = 0;

  function automatic logic [RES_W-1:0] rand_word();
    logic [RES_W-1:0] r;
    for (int i = 0; i < RES_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_beat = 0;
    m_ovf  = 1'b0;
    m_done = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic cycle(input bit en, input logic [ADDR_W-1:0] a,
                       input logic [RES_W-1:0] d, input bit rdy);
    bit    m_fire, m_pop, m_acc;
    word_t w;
    beat_t b;
    res_en   = en;
    res_addr = a;
    res_data = d;
    wr_ready = rdy;
    #1;
    if (wr_valid && wr_ready) begin
      b.addr = wr_addr; b.data = wr_data; b.cyc = cyc_no;
      obs_q.push_back(b);
      if (wr_addr[2:0] == 3'd7)
        $display("[TB] cycle %0d: word 0x%04h last beat written", cyc_no, wr_addr[WA_W-1:3]);
    end
    m_fire = (m_q.size() != 0) && rdy;
    m_pop  = m_fire && (m_beat == NBEAT-1);
    m_acc  = en && ((m_q.size() < DEPTH) || m_pop);
    if (m_fire) begin
      b.addr = {m_q[0].addr, 3'(m_beat)};
      b.data = m_q[0].data[m_beat*BEAT_W +: BEAT_W];
      b.cyc  = cyc_no;
      exp_q.push_back(b);
    end
    @(posedge clk);
    if (m_fire) begin
      if (m_pop) begin
        void'(m_q.pop_front());
        m_beat = 0;
        m_done = m_done + 16'd1;
      end else begin
        m_beat++;
      end
    end
    if (m_acc) begin
      w.addr = a; w.data = d;
      m_q.push_back(w);
    end else if (en) begin
      m_ovf = 1'b1;
    end
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy);
  endtask

  task automatic apply_reset();
    res_en = 1'b0; wr_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0; res_en = 1'b0; wr_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid: got %0b expected 0", wr_valid); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr: got 0x%0h expected 0", wr_addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL reset_wr_data: got 0x%0h expected 0", wr_data[63:0]); end
    tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_res_ready: got %0b expected 1", res_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    tests_run++; if (words_done !== 16'd0) begin tests_failed++; $display("FAIL reset_words_done: got %0d expected 0", words_done); end
    rstn = 1'b1;
    model_reset();
    idle(2, 1'b1);
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_wr_valid: got %0b expected 0", wr_valid); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    logic [RES_W-1:0]  pat;
    logic [7:0]        bv;
    logic [BEAT_W-1:0] ed;
    int                t;
    for (int k = 0; k < NBEAT; k++) begin
      bv = 8'(k + 1);
      pat[k*BEAT_W +: BEAT_W] = {128{bv}};
    end
    exp_q.delete(); obs_q.delete();
    t = cyc_no;
    cycle(1'b1, 16'h0005, pat, 1'b1);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_active: got %0b expected 1", busy); end
    idle(10, 1'b1);
    tests_run++;
    if (obs_q.size() != NBEAT) begin tests_failed++; $display("FAIL single_count: got %0d beats expected %0d", obs_q.size(), NBEAT); end
    for (int k = 0; k < NBEAT && k < obs_q.size(); k++) begin
      bv = 8'(k + 1);
      ed = {128{bv}};
      tests_run++;
      if (obs_q[k].addr !== WA_W'(8'h28 + k) || obs_q[k].data !== ed || obs_q[k].cyc != t + 1 + k) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                 k, obs_q[k].addr, obs_q[k].data[63:0], obs_q[k].cyc, 8'h28 + k, ed[63:0], t + 1 + k);
      end
    end
    tests_run++; if (words_done !== 16'd1) begin tests_failed++; $display("FAIL single_words_done: got %0d expected 1", words_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_idle: got %0b expected 0", busy); end
    $display("[TB] test_single done");
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0]  d;
    logic [WA_W-1:0]   prev_a;
    logic [BEAT_W-1:0] prev_d;
    bit                stalled;
    bit                rdy;
    d = rand_word();
    exp_q.delete(); obs_q.delete();
    cycle(1'b1, 16'h0005, d, 1'b1);
    stalled = 1'b0; prev_a = '0; prev_d = '0;
    for (int i = 0; i < 40; i++) begin
      rdy = (i % 3 == 0);
      if (stalled) begin
        tests_run++;
        if (wr_valid !== 1'b1 || wr_addr !== prev_a || wr_data !== prev_d) begin
          tests_failed++;
          $display("FAIL bp_hold: got valid %0b addr 0x%0h data 0x%0h expected valid 1 addr 0x%0h data 0x%0h",
                   wr_valid, wr_addr, wr_data[63:0], prev_a, prev_d[63:0]);
        end
      end
      stalled = wr_valid && !rdy;
      prev_a = wr_addr; prev_d = wr_data;
      cycle(1'b0, '0, '0, rdy);
    end
    idle(4, 1'b1);
    tests_run++;
    if (obs_q.size() != NBEAT) begin tests_failed++; $display("FAIL bp_count: got %0d beats expected %0d", obs_q.size(), NBEAT); end
    for (int k = 0; k < NBEAT && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k].addr !== WA_W'(8'h28 + k) || obs_q[k].data !== d[k*BEAT_W +: BEAT_W]) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                 k, obs_q[k].addr, obs_q[k].data[63:0], 8'h28 + k, d[k*BEAT_W +: 64]);
      end
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [RES_W-1:0]  wa, wb;
    logic [WA_W-1:0]   ea;
    logic [BEAT_W-1:0] ed;
    wa = rand_word(); wb = rand_word();
    exp_q.delete(); obs_q.delete();
    cycle(1'b1, 16'h0001, wa, 1'b1);
    cycle(1'b1, 16'h0002, wb, 1'b1);
    idle(20, 1'b1);
    tests_run++;
    if (obs_q.size() != 2*NBEAT) begin tests_failed++; $display("FAIL b2b_count: got %0d beats expected %0d", obs_q.size(), 2*NBEAT); end
    for (int i = 0; i < 2*NBEAT && i < obs_q.size(); i++) begin
      ea = (i < NBEAT) ? WA_W'(8'h08 + i) : WA_W'(8'h10 + i - NBEAT);
      ed = (i < NBEAT) ? wa[i*BEAT_W +: BEAT_W] : wb[(i-NBEAT)*BEAT_W +: BEAT_W];
      tests_run++;
      if (obs_q[i].addr !== ea || obs_q[i].data !== ed || obs_q[i].cyc != obs_q[0].cyc + i) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                 i, obs_q[i].addr, obs_q[i].data[63:0], obs_q[i].cyc, ea, ed[63:0], obs_q[0].cyc + i);
      end
    end
    tests_run++; if (words_done !== m_done) begin tests_failed++; $display("FAIL b2b_words_done: got %0d expected %0d", words_done, m_done); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_overflow();
    logic [RES_W-1:0]  w1, w2, w3;
    logic [WA_W-1:0]   ea;
    logic [BEAT_W-1:0] ed;
    w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
    exp_q.delete(); obs_q.delete();
    cycle(1'b1, 16'h0001, w1, 1'b0);
    tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready_one: got %0b expected 1", res_ready); end
    cycle(1'b1, 16'h0002, w2, 1'b0);
    tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_ready_full: got %0b expected 0", res_ready); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before: got %0b expected 0", overflow); end
    cycle(1'b1, 16'h0003, w3, 1'b0);
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    idle(24, 1'b1);
    tests_run++;
    if (obs_q.size() != 2*NBEAT) begin tests_failed++; $display("FAIL ovf_count: got %0d beats expected %0d", obs_q.size(), 2*NBEAT); end
    for (int i = 0; i < 2*NBEAT && i < obs_q.size(); i++) begin
      ea = {16'(i/NBEAT + 1), 3'(i % NBEAT)};
      ed = (i < NBEAT) ? w1[i*BEAT_W +: BEAT_W] : w2[(i-NBEAT)*BEAT_W +: BEAT_W];
      tests_run++;
      if (obs_q[i].addr !== ea || obs_q[i].data !== ed) begin
        tests_failed++;
        $display("FAIL ovf_beat%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                 i, obs_q[i].addr, obs_q[i].data[63:0], ea, ed[63:0]);
      end
    end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_push_on_pop_full();
    logic [RES_W-1:0]  ws [3];
    logic [WA_W-1:0]   ea;
    logic [BEAT_W-1:0] ed;
    for (int i = 0; i < 3; i++) ws[i] = rand_word();
    exp_q.delete(); obs_q.delete();
    cycle(1'b1, 16'h0001, ws[0], 1'b1);
    cycle(1'b1, 16'h0002, ws[1], 1'b1);
    for (int n = 0; n < 20 && !(m_q.size() == DEPTH && m_beat == NBEAT-1); n++) idle(1, 1'b1);
    tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL pop_push_full: got res_ready %0b expected 0", res_ready); end
    cycle(1'b1, 16'h0003, ws[2], 1'b1);
    idle(30, 1'b1);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pop_push_ovf: got %0b expected 0", overflow); end
    tests_run++;
    if (obs_q.size() != 3*NBEAT) begin tests_failed++; $display("FAIL pop_push_count: got %0d beats expected %0d", obs_q.size(), 3*NBEAT); end
    for (int i = 0; i < 3*NBEAT && i < obs_q.size(); i++) begin
      ea = {16'(i/NBEAT + 1), 3'(i % NBEAT)};
      ed = ws[i/NBEAT][(i % NBEAT)*BEAT_W +: BEAT_W];
      tests_run++;
      if (obs_q[i].addr !== ea || obs_q[i].data !== ed) begin
        tests_failed++;
        $display("FAIL pop_push_beat%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                 i, obs_q[i].addr, obs_q[i].data[63:0], ea, ed[63:0]);
      end
    end
    tests_run++; if (words_done !== 16'd3) begin tests_failed++; $display("FAIL pop_push_words_done: got %0d expected 3", words_done); end
    $display("[TB] test_push_on_pop_full done");
  endtask

  task automatic test_reset_mid();
    logic [RES_W-1:0]  d;
    logic [ADDR_W-1:0] a;
    int                t;
    d = rand_word();
    exp_q.delete(); obs_q.delete();
    cycle(1'b1, 16'h0009, d, 1'b1);
    idle(4, 1'b1);
    tests_run++; if (obs_q.size() != 4) begin tests_failed++; $display("FAIL rstmid_prebeats: got %0d beats expected 4", obs_q.size()); end
    rstn = 1'b0;
    #1;
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_wr_valid: got %0b expected 0", wr_valid); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL rstmid_wr_addr: got 0x%0h expected 0", wr_addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL rstmid_wr_data: got 0x%0h expected 0", wr_data[63:0]); end
    tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_res_ready: got %0b expected 1", res_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    tests_run++; if (words_done !== 16'd0) begin tests_failed++; $display("FAIL rstmid_words_done: got %0d expected 0", words_done); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    a = 16'($urandom);
    d = rand_word();
    t = cyc_no;
    cycle(1'b1, a, d, 1'b1);
    idle(10, 1'b1);
    tests_run++;
    if (obs_q.size() != NBEAT) begin tests_failed++; $display("FAIL rstmid_count: got %0d beats expected %0d", obs_q.size(), NBEAT); end
    for (int k = 0; k < NBEAT && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k].addr !== {a, 3'(k)} || obs_q[k].data !== d[k*BEAT_W +: BEAT_W] || obs_q[k].cyc != t + 1 + k) begin
        tests_failed++;
        $display("FAIL rstmid_beat%0d: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                 k, obs_q[k].addr, obs_q[k].data[63:0], obs_q[k].cyc, {a, 3'(k)}, d[k*BEAT_W +: 64], t + 1 + k);
      end
    end
    tests_run++; if (words_done !== 16'd1) begin tests_failed++; $display("FAIL rstmid_words_after: got %0d expected 1", words_done); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    bit en, rdy;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) < 35);
      rdy = ($urandom_range(0, 99) < 65);
      if (en) cycle(1'b1, 16'($urandom), rand_word(), rdy);
      else    cycle(1'b0, '0, '0, rdy);
    end
    idle(30, 1'b1);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc) begin
        tests_failed++;
        $display("FAIL rand_beat%0d: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                 i, obs_q[i].addr, obs_q[i].data[63:0], obs_q[i].cyc, exp_q[i].addr, exp_q[i].data[63:0], exp_q[i].cyc);
      end
    end
    tests_run++; if (overflow !== m_ovf) begin tests_failed++; $display("FAIL rand_overflow: got %0b expected %0b", overflow, m_ovf); end
    tests_run++; if (words_done !== m_done) begin tests_failed++; $display("FAIL rand_words_done: got %0d expected %0d", words_done, m_done); end
    tests_run++; if (busy !== 1'b0 || res_ready !== 1'b1) begin tests_failed++; $display("FAIL rand_final_idle: got busy %0b res_ready %0b expected 0 1", busy, res_ready); end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    apply_reset();
    test_push_on_pop_full();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
